gcd_host_driver: RTL and testbench
==================================

Name: gcd_host_driver

Overview:
Hardware initiator for the GCD Processor, moving operand loading out of the testbench into logic. Accepts an operand pair on a valid/ready request port and resets the Processor. Loads X then Y with single-cycle Enter pulses, waits for Halt, and returns Output on a valid/ready response port. Sits between a system requester and the Processor instance.

Parameters:
WIDTH, 8, operand/result width; matches Processor Input/Output.
SETTLE, 15, idle cycles inserted before each Enter pulse; range 1..255.
TIMEOUT, 1023, maximum WAIT cycles before error; range 1..65535.

Ports:
Clock  input  1  system clock, rising edge.
Reset  input  1  asynchronous, active-high reset.
ReqValid  input  1  request pair valid.
ReqReady  output  1  driver can accept a request.
ReqX  input  WIDTH  first operand.
ReqY  input  WIDTH  second operand.
RspValid  output  1  result available.
RspReady  input  1  consumer accepts result.
RspResult  output  WIDTH  GCD result; 0 on error.
RspError  output  1  zero operand or timeout.
Busy  output  1  high whenever state is not IDLE.
ProcReset  output  1  drives Processor Reset.
ProcEnter  output  1  drives Processor Enter.
ProcInput  output  WIDTH  drives Processor Input.
ProcHalt  input  1  Processor Halt.
ProcOutput  input  WIDTH  Processor Output.

Behaviour:
- Reset values: ReqReady=0, RspValid=0, RspResult=0, RspError=0, Busy=0, ProcReset=1, ProcEnter=0, ProcInput=0. The Processor is held in reset while Reset is high.
- All outputs are registered. On the first edge after Reset release: IDLE, ProcReset=0, ReqReady=1.
- States: IDLE, PRST, GAP1, ENTX, GAP2, ENTY, WAIT, RESP.
- IDLE: ReqReady=1. On ReqValid&&ReqReady, latch ReqX/ReqY.
  - If either operand is 0: go to RESP with RspError=1, RspResult=0. The Processor is not touched.
  - Otherwise: go to PRST.
- PRST: ProcReset=1 for exactly 1 cycle, then GAP1.
- GAP1: SETTLE cycles with ProcEnter=0, then ENTX.
- ENTX: ProcEnter=1 and ProcInput=X for exactly 1 cycle, then GAP2.
- GAP2: SETTLE cycles, then ENTY.
- ENTY: ProcEnter=1 and ProcInput=Y for exactly 1 cycle, then WAIT.
- ProcInput holds its last value outside Enter cycles. It returns to 0 only on Reset.
- WAIT: ProcHalt is ignored in the first WAIT cycle (blanking).
  - From the second cycle on, ProcHalt=1 captures ProcOutput into RspResult with RspError=0, then RESP.
  - A cycle counter starts at 0 on entry. If it reaches TIMEOUT without a qualifying Halt: RspResult=0, RspError=1, then RESP.
  - Halt and timeout in the same cycle: Halt wins.
- RESP: RspValid=1, and RspResult/RspError stay stable until RspValid&&RspReady. Then go to IDLE with RspValid=0.
- ReqReady=1 only in IDLE. A request presented in any other state is not accepted and must be held by the requester.
- Minimum latency, accept edge to RspValid rising, with an immediate Halt: 1 (PRST) + SETTLE + 1 + SETTLE + 1 + 2 (WAIT) cycles. With defaults this is 35 cycles.
- Back-to-back: after a RESP handshake, IDLE lasts at least 1 cycle before the next accept. Each request re-resets the Processor.
- Reset mid-operation (any state): all outputs return asynchronously to reset values, including ProcReset=1. Latched operands, counters and any pending response are discarded.

Test Plan:
- Basic: behavioural Processor model raising Halt 10 cycles after the Y Enter; request (48,18) -> exactly one ProcReset pulse, then ProcEnter pulses carrying 48 then 18 spaced 16 cycles apart, then RspValid with RspResult=6, RspError=0.
- Zero operand: request (0,25) -> no ProcReset or ProcEnter activity; RspValid within 2 cycles with RspResult=0, RspError=1.
- Timeout: TIMEOUT=20 and ProcHalt tied to 0; request (7,3) -> RspError=1, RspResult=0 exactly 20 WAIT cycles after the ENTY cycle.
- Back-pressure: RspReady held low for 5 cycles after RspValid; request (81,27) -> RspResult=27 stays stable with RspValid=1 throughout and ReqReady=0; the next request is accepted only after the handshake.
- Reset mid-WAIT: assert Reset 3 cycles into WAIT -> ProcReset=1 and RspValid=0 immediately. After release, a new request (100,75) returns 25 with no stale result.
- Stale-Halt blanking: ProcHalt forced high in the first WAIT cycle only, then low for 4 cycles, then high; request (9,6) -> result is the ProcOutput value from the second Halt assertion (3), not the first.

Source files
------------

// File: rtl/gcd_host_driver.sv
// gcd_host_driver
// Initiator for the GCD Processor. It accepts one operand pair on a
// valid/ready request port, resets the Processor, loads X then Y with
// single-cycle Enter pulses separated by SETTLE idle cycles, waits for Halt,
// and then returns the Processor Output on a valid/ready response port.
//
// Handshakes: a transfer happens on a rising Clock edge where both valid and
// ready are high. Once valid is raised, it stays high with its payload stable
// until that transfer. ReqReady is high only in IDLE. A requester that raises
// ReqValid in any other state must hold the request until it is accepted.
//
// Ports:
//   Clock, Reset            rising-edge clock, async active-high reset
//   ReqValid/ReqReady       request handshake, payload ReqX/ReqY
//   RspValid/RspReady       response handshake, payload RspResult/RspError
//   Busy                    high whenever the FSM is not in IDLE
//   ProcReset/ProcEnter/ProcInput   drive the Processor
//   ProcHalt/ProcOutput     Processor status and result
//   debug_state             current FSM state, for observation only
module gcd_host_driver #(
  parameter int WIDTH   = 8,
  parameter int SETTLE  = 15,
  parameter int TIMEOUT = 1023
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             ReqValid,
  output logic             ReqReady,
  input  logic [WIDTH-1:0] ReqX,
  input  logic [WIDTH-1:0] ReqY,
  output logic             RspValid,
  input  logic             RspReady,
  output logic [WIDTH-1:0] RspResult,
  output logic             RspError,
  output logic             Busy,
  output logic             ProcReset,
  output logic             ProcEnter,
  output logic [WIDTH-1:0] ProcInput,
  input  logic             ProcHalt,
  input  logic [WIDTH-1:0] ProcOutput,
  output logic [2:0]       debug_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRST = 3'd1,
    S_GAP1 = 3'd2,
    S_ENTX = 3'd3,
    S_GAP2 = 3'd4,
    S_ENTY = 3'd5,
    S_WAIT = 3'd6,
    S_RESP = 3'd7
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [15:0]      cnt;
  logic [15:0]      cnt_d;
  logic [WIDTH-1:0] x_q;
  logic [WIDTH-1:0] y_q;

  logic             accept;
  logic             zero_op;
  logic             gap_done;
  logic             halt_ok;
  logic             timeout_hit;

  logic             req_ready_d;
  logic             rsp_valid_d;
  logic [WIDTH-1:0] rsp_result_d;
  logic             rsp_error_d;
  logic             busy_d;
  logic             proc_reset_d;
  logic             proc_enter_d;
  logic [WIDTH-1:0] proc_input_d;

  assign debug_state = state;

  assign accept   = (state == S_IDLE) && ReqValid && ReqReady;
  assign zero_op  = (ReqX == '0) || (ReqY == '0);
  assign gap_done = (cnt == 16'(SETTLE - 1));
  // cnt is 0 during the first WAIT cycle, so Halt is blanked there. A Halt
  // that is still high from before the Processor reset is ignored this way.
  assign halt_ok     = (state == S_WAIT) && ProcHalt && (cnt != 16'd0);
  assign timeout_hit = (state == S_WAIT) && (cnt == 16'(TIMEOUT - 1));

  // State register
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: if (accept) next_state = zero_op ? S_RESP : S_PRST;
      S_PRST: next_state = S_GAP1;
      S_GAP1: if (gap_done) next_state = S_ENTX;
      S_ENTX: next_state = S_GAP2;
      S_GAP2: if (gap_done) next_state = S_ENTY;
      S_ENTY: next_state = S_WAIT;
      S_WAIT: if (halt_ok || timeout_hit) next_state = S_RESP;
      S_RESP: if (RspValid && RspReady) next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Output logic. The values are computed from next_state and then
  // registered, so every output follows the state it belongs to.
  always_comb begin
    req_ready_d  = (next_state == S_IDLE);
    busy_d       = (next_state != S_IDLE);
    proc_reset_d = (next_state == S_PRST);
    proc_enter_d = (next_state == S_ENTX) || (next_state == S_ENTY);
    rsp_valid_d  = (next_state == S_RESP);

    // ProcInput keeps its last loaded operand between Enter pulses.
    proc_input_d = ProcInput;
    if (next_state == S_ENTX) begin
      proc_input_d = x_q;
    end else if (next_state == S_ENTY) begin
      proc_input_d = y_q;
    end

    // The response fields change only on entry to RESP. When Halt and the
    // timeout occur in the same cycle, Halt takes priority.
    rsp_result_d = RspResult;
    rsp_error_d  = RspError;
    if (accept && zero_op) begin
      rsp_result_d = '0;
      rsp_error_d  = 1'b1;
    end else if (halt_ok) begin
      rsp_result_d = ProcOutput;
      rsp_error_d  = 1'b0;
    end else if (timeout_hit) begin
      rsp_result_d = '0;
      rsp_error_d  = 1'b1;
    end
  end

  // A single counter serves GAP1, GAP2 and WAIT. It restarts at 0 on every
  // state change.
  always_comb begin
    cnt_d = cnt;
    if (next_state != state) begin
      cnt_d = 16'd0;
    end else if ((state == S_GAP1) || (state == S_GAP2) || (state == S_WAIT)) begin
      cnt_d = cnt + 16'd1;
    end
  end

  // Output and datapath registers
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      ReqReady  <= 1'b0;
      RspValid  <= 1'b0;
      RspResult <= '0;
      RspError  <= 1'b0;
      Busy      <= 1'b0;
      ProcReset <= 1'b1;
      ProcEnter <= 1'b0;
      ProcInput <= '0;
      cnt       <= 16'd0;
      x_q       <= '0;
      y_q       <= '0;
    end else begin
      ReqReady  <= req_ready_d;
      RspValid  <= rsp_valid_d;
      RspResult <= rsp_result_d;
      RspError  <= rsp_error_d;
      Busy      <= busy_d;
      ProcReset <= proc_reset_d;
      ProcEnter <= proc_enter_d;
      ProcInput <= proc_input_d;
      cnt       <= cnt_d;
      if (accept) begin
        x_q <= ReqX;
        y_q <= ReqY;
      end
    end
  end

endmodule

// File: tb/tb_gcd_host_driver.sv
// tb_gcd_host_driver
// Directed bench for gcd_host_driver. The main instance runs with the default
// parameters and drives a small behavioural GCD Processor. That Processor's
// Halt/Output can be overridden for the stale-Halt case. A second instance has
// TIMEOUT=20 and ProcHalt tied low, and covers the timeout path.
// Cycle index k counts falling edges after the accept edge. k=0 is the first
// falling edge after the request was taken.
module tb_gcd_host_driver;

  // Clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Main instance signals
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [7:0] req_x = 8'd0;
  logic [7:0] req_y = 8'd0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_result;
  logic       rsp_error;
  logic       busy;
  logic       proc_reset;
  logic       proc_enter;
  logic [7:0] proc_input;
  logic       proc_halt;
  logic [7:0] proc_output;
  logic [2:0] debug_state;

  // Timeout instance signals
  logic       t_req_valid = 1'b0;
  logic       t_req_ready;
  logic [7:0] t_req_x = 8'd0;
  logic [7:0] t_req_y = 8'd0;
  logic       t_rsp_valid;
  logic [7:0] t_rsp_result;
  logic       t_rsp_error;
  logic       t_busy;
  logic       t_proc_reset;
  logic       t_proc_enter;
  logic [7:0] t_proc_input;
  logic [2:0] t_debug_state;

  gcd_host_driver u_dut (
    .Clock(clk), .Reset(rst),
    .ReqValid(req_valid), .ReqReady(req_ready), .ReqX(req_x), .ReqY(req_y),
    .RspValid(rsp_valid), .RspReady(rsp_ready), .RspResult(rsp_result), .RspError(rsp_error),
    .Busy(busy), .ProcReset(proc_reset), .ProcEnter(proc_enter), .ProcInput(proc_input),
    .ProcHalt(proc_halt), .ProcOutput(proc_output), .debug_state(debug_state)
  );

  gcd_host_driver #(.WIDTH(8), .SETTLE(15), .TIMEOUT(20)) u_dut_to (
    .Clock(clk), .Reset(rst),
    .ReqValid(t_req_valid), .ReqReady(t_req_ready), .ReqX(t_req_x), .ReqY(t_req_y),
    .RspValid(t_rsp_valid), .RspReady(1'b1), .RspResult(t_rsp_result), .RspError(t_rsp_error),
    .Busy(t_busy), .ProcReset(t_proc_reset), .ProcEnter(t_proc_enter), .ProcInput(t_proc_input),
    .ProcHalt(1'b0), .ProcOutput(8'h55), .debug_state(t_debug_state)
  );

  // Behavioural GCD Processor: it takes X then Y on Enter and raises Halt
  // about 10 cycles after the Y Enter.
  logic [7:0] m_a, m_b, m_out;
  logic       m_have_x, m_run, m_halt;
  int         m_cnt;

  function automatic logic [7:0] gcd8(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] x, y, t;
    x = a;
    y = b;
    while (y != 8'd0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_a <= 8'd0; m_b <= 8'd0; m_out <= 8'd0;
      m_have_x <= 1'b0; m_run <= 1'b0; m_halt <= 1'b0; m_cnt <= 0;
    end else if (proc_reset) begin
      m_have_x <= 1'b0; m_run <= 1'b0; m_halt <= 1'b0; m_cnt <= 0; m_out <= 8'd0;
    end else if (proc_enter) begin
      if (!m_have_x) begin
        m_a <= proc_input;
        m_have_x <= 1'b1;
      end else begin
        m_b <= proc_input;
        m_run <= 1'b1;
        m_cnt <= 0;
      end
    end else if (m_run) begin
      if (m_cnt == 9) begin
        m_halt <= 1'b1;
        m_out <= gcd8(m_a, m_b);
        m_run <= 1'b0;
      end else begin
        m_cnt <= m_cnt + 1;
      end
    end
  end

  // Override for directed Halt sequences
  logic       ovr_en = 1'b0;
  logic       ovr_halt = 1'b0;
  logic [7:0] ovr_out = 8'd0;
  assign proc_halt   = ovr_en ? ovr_halt : m_halt;
  assign proc_output = ovr_en ? ovr_out : m_out;

  // Scoreboard counters
  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic send_req(input logic [7:0] x, input logic [7:0] y);
    int n;
    n = 0;
    req_x = x;
    req_y = y;
    req_valid = 1'b1;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("accept_bound", 32'(n < 50), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int budget, output int k);
    k = 0;
    while (!rsp_valid && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("rsp_bound", 32'(k < budget), 32'd1);
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  int n_rst, rst_k, n_ent, rsp_k, k_w;
  int ent_k[2];
  logic [7:0] ent_v[2];

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    repeat (2) @(negedge clk);
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_result", rsp_result, 0);
    check("rst_rsp_error", rsp_error, 0);
    check("rst_busy", busy, 0);
    check("rst_proc_reset", proc_reset, 1);
    check("rst_proc_enter", proc_enter, 0);
    check("rst_proc_input", proc_input, 0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_req_ready", req_ready, 1);
    check("post_rst_proc_reset", proc_reset, 0);
    check("post_rst_state", debug_state, 0);

    // Basic (48,18)
    send_req(8'd48, 8'd18);
    check("basic_busy", busy, 1);
    check("basic_req_ready", req_ready, 0);
    n_rst = 0; rst_k = -1; n_ent = 0; rsp_k = -1;
    for (int k = 0; k < 120 && rsp_k < 0; k++) begin
      if (proc_reset) begin n_rst++; rst_k = k; end
      if (proc_enter) begin
        if (n_ent < 2) begin ent_k[n_ent] = k; ent_v[n_ent] = proc_input; end
        n_ent++;
      end
      if (rsp_valid) rsp_k = k;
      else @(negedge clk);
    end
    check("basic_rsp_seen", 32'(rsp_k >= 0), 1);
    check("basic_reset_pulses", n_rst, 1);
    check("basic_reset_k", rst_k, 0);
    check("basic_enter_pulses", n_ent, 2);
    check("basic_enter_x_k", ent_k[0], 16);
    check("basic_enter_y_k", ent_k[1], 32);
    check("basic_enter_x_val", ent_v[0], 48);
    check("basic_enter_y_val", ent_v[1], 18);
    check("basic_result", rsp_result, 6);
    check("basic_error", rsp_error, 0);
    handshake();
    check("basic_done_valid", rsp_valid, 0);
    check("basic_done_ready", req_ready, 1);
    check("basic_done_busy", busy, 0);

    // Zero operand (0,25)
    send_req(8'd0, 8'd25);
    check("zero_valid", rsp_valid, 1);
    check("zero_error", rsp_error, 1);
    check("zero_result", rsp_result, 0);
    check("zero_proc_reset", proc_reset, 0);
    check("zero_proc_enter", proc_enter, 0);
    @(negedge clk);
    check("zero_proc_reset2", proc_reset, 0);
    check("zero_proc_enter2", proc_enter, 0);
    check("zero_valid2", rsp_valid, 1);
    handshake();

    // Back-pressure (81,27), with the next request (12,8) held meanwhile
    send_req(8'd81, 8'd27);
    wait_rsp(100, k_w);
    req_x = 8'd12; req_y = 8'd8; req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", rsp_valid, 1);
      check("bp_result", rsp_result, 27);
      check("bp_req_ready", req_ready, 0);
      @(negedge clk);
    end
    check("bp_error", rsp_error, 0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("bp_hs_valid", rsp_valid, 0);
    check("bp_hs_not_taken", proc_reset, 0);
    check("bp_hs_ready", req_ready, 1);
    @(negedge clk);
    req_valid = 1'b0;
    check("bp_next_taken", proc_reset, 1);
    check("bp_next_busy", busy, 1);

    // Reset mid-WAIT: the (12,8) run is now at k=0
    repeat (35) @(negedge clk);
    check("mid_in_wait", debug_state, 6);
    rst = 1'b1;
    #1;
    check("mid_proc_reset", proc_reset, 1);
    check("mid_rsp_valid", rsp_valid, 0);
    check("mid_req_ready", req_ready, 0);
    check("mid_busy", busy, 0);
    check("mid_proc_input", proc_input, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("mid_release_ready", req_ready, 1);
    send_req(8'd100, 8'd75);
    wait_rsp(100, k_w);
    check("mid_new_result", rsp_result, 25);
    check("mid_new_error", rsp_error, 0);
    handshake();

    // Stale-Halt blanking (9,6)
    send_req(8'd9, 8'd6);
    repeat (33) @(negedge clk);
    ovr_en = 1'b1; ovr_halt = 1'b1; ovr_out = 8'hEE;
    @(negedge clk);
    ovr_halt = 1'b0;
    check("stale_blank_valid", rsp_valid, 0);
    repeat (4) @(negedge clk);
    check("stale_gap_valid", rsp_valid, 0);
    ovr_halt = 1'b1; ovr_out = 8'd3;
    @(negedge clk);
    check("stale_valid", rsp_valid, 1);
    check("stale_result", rsp_result, 3);
    check("stale_error", rsp_error, 0);
    handshake();
    ovr_en = 1'b0;

    // Timeout instance (7,3) with Halt tied low
    t_req_x = 8'd7; t_req_y = 8'd3; t_req_valid = 1'b1;
    check("to_ready", t_req_ready, 1);
    @(negedge clk);
    t_req_valid = 1'b0;
    repeat (32) @(negedge clk);
    check("to_enty_enter", t_proc_enter, 1);
    check("to_enty_input", t_proc_input, 3);
    repeat (20) @(negedge clk);
    check("to_early_valid", t_rsp_valid, 0);
    @(negedge clk);
    check("to_valid", t_rsp_valid, 1);
    check("to_error", t_rsp_error, 1);
    check("to_result", t_rsp_result, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
